// File: rtl/serial_parity_checker.sv
// Serial frame receiver with even/odd parity check: DATA_W bits LSB first, then one parity bit.
// Optional saturating failed-frame counter (err_count) enabled by defining PARITY_ERR_CNT_EN.
module serial_parity_checker #(
   parameter int DATA_W     = 8,
   parameter int ODD_PARITY = 0,
   parameter int CNT_W      = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              din,
   input  logic              din_valid,
   output logic              busy,
   output logic [DATA_W-1:0] data_out,
   output logic              parity_ok,
`ifdef PARITY_ERR_CNT_EN
   output logic [CNT_W-1:0]  err_count,
`endif
   output logic              frame_done
);

   localparam int               BIT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
   localparam logic             ODD_BIT  = (ODD_PARITY != 0);

   if (DATA_W < 1 || CNT_W < 1) begin : g_param_check
      $error("serial_parity_checker: DATA_W and CNT_W must be >= 1");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_PARITY,
      S_DONE
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] shreg;
   logic              acc;
   logic [BIT_W-1:0]  bit_cnt;
   logic              parity_good;

   // Verdict for the parity bit presented this cycle; only consumed in S_PARITY.
   assign parity_good = ((acc ^ din) == ODD_BIT);

   // NOTE: every register here is written with <= so all updates see pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         shreg      <= '0;
         acc        <= 1'b0;
         bit_cnt    <= '0;
         busy       <= 1'b0;
         data_out   <= '0;
         parity_ok  <= 1'b0;
         frame_done <= 1'b0;
`ifdef PARITY_ERR_CNT_EN
         err_count  <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               acc     <= 1'b0;
               bit_cnt <= '0;
               shreg   <= '0;
               if (start) begin
                  state <= S_DATA;
                  busy  <= 1'b1;
               end
            end
            S_DATA: begin
               if (din_valid) begin
                  shreg[bit_cnt] <= din;
                  acc            <= acc ^ din;
                  // Counter parks on the last index instead of wrapping.
                  if (bit_cnt == LAST_BIT) state <= S_PARITY;
                  else                     bit_cnt <= bit_cnt + 1'b1;
               end
            end
            S_PARITY: begin
               if (din_valid) begin
                  data_out   <= shreg;
                  parity_ok  <= parity_good;
                  frame_done <= 1'b1;
                  busy       <= 1'b0;
                  state      <= S_DONE;
`ifdef PARITY_ERR_CNT_EN
                  if (!parity_good && (err_count != {CNT_W{1'b1}}))
                     err_count <= err_count + 1'b1;
`endif
               end
            end
            S_DONE: begin
               frame_done <= 1'b0;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_parity_checker.sv
// Self-checking bench: an even-parity and an odd-parity (CNT_W=2) instance share one serial stream;
// expectations come from popcount arithmetic over each frame's data plus parity bit.
module tb_serial_parity_checker;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       din = 1'b0;
   logic       din_valid = 1'b0;

   logic       e_busy, e_ok, e_done;
   logic [7:0] e_data;
   logic       o_busy, o_ok, o_done;
   logic [7:0] o_data;
`ifdef PARITY_ERR_CNT_EN
   logic [7:0] e_err;
   logic [1:0] o_err;
`endif

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int done_e_cnt = 0, done_o_cnt = 0;
   int last_done_cyc = -1;

   logic [7:0] exp_data = '0;
   logic       exp_ok_e = 1'b0, exp_ok_o = 1'b0;
   int         exp_err_e = 0, exp_err_o = 0;

   serial_parity_checker #(.DATA_W(8), .ODD_PARITY(0), .CNT_W(8)) dut_even (
      .clk(clk), .rst(rst), .start(start), .din(din), .din_valid(din_valid),
      .busy(e_busy), .data_out(e_data), .parity_ok(e_ok),
`ifdef PARITY_ERR_CNT_EN
      .err_count(e_err),
`endif
      .frame_done(e_done)
   );

   serial_parity_checker #(.DATA_W(8), .ODD_PARITY(1), .CNT_W(2)) dut_odd (
      .clk(clk), .rst(rst), .start(start), .din(din), .din_valid(din_valid),
      .busy(o_busy), .data_out(o_data), .parity_ok(o_ok),
`ifdef PARITY_ERR_CNT_EN
      .err_count(o_err),
`endif
      .frame_done(o_done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (e_done) begin
         done_e_cnt++;
         last_done_cyc = cyc;
      end
      if (o_done) done_o_cnt++;
   endtask

   task automatic apply_reset();
      rst = 1'b1; start = 1'b1; din_valid = 1'b1; din = 1'($urandom);
      tick(); tick();
      rst = 1'b0; start = 1'b0; din_valid = 1'b0;
      exp_data = '0; exp_ok_e = 1'b0; exp_ok_o = 1'b0; exp_err_e = 0; exp_err_o = 0;
   endtask

   // Drives one frame from start to the return to IDLE and checks the DONE cycle against the model.
   task automatic run_frame(input string name, input logic [7:0] data, input logic p,
                            input int max_stall, input int mid_stall, input int pre_stall,
                            input bit glitch_mid, input bit glitch_done, output int latency);
      logic [17:0] snap;
      int e0, o0, start_cyc, held_bad, ones;
      snap = {e_data, e_ok, o_data, o_ok};
      e0 = done_e_cnt; o0 = done_o_cnt; held_bad = 0; start_cyc = cyc;
      start = 1'b1; din = 1'($urandom); din_valid = 1'($urandom);
      tick();
      start = 1'b0;
      total++;
      if ({e_busy, o_busy} !== 2'b11) begin
         bad++; $display("FAIL %s busy_after_start: got %b want 11", name, {e_busy, o_busy});
      end
      for (int i = 0; i < 8; i++) begin
         int n;
         n = (max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0;
         if (i == 3) n += mid_stall;
         repeat (n) begin
            din_valid = 1'b0; din = 1'($urandom); tick();
         end
         din_valid = 1'b1; din = data[i]; start = glitch_mid && (i == 3);
         tick();
         start = 1'b0;
         if ({e_data, e_ok, o_data, o_ok} !== snap) held_bad++;
      end
      repeat (pre_stall) begin
         din_valid = 1'b0; din = 1'($urandom); tick();
         if ({e_data, e_ok, o_data, o_ok} !== snap) held_bad++;
      end
      total++;
      if (held_bad != 0) begin
         bad++; $display("FAIL %s hold_prev_result: %0d cycles changed, want 0", name, held_bad);
      end
      total++;
      if ((done_e_cnt != e0) || (done_o_cnt != o0)) begin
         bad++; $display("FAIL %s early_done: got %0d/%0d pulses want 0", name, done_e_cnt - e0, done_o_cnt - o0);
      end
      din_valid = 1'b1; din = p;
      tick();
      din_valid = 1'b0; din = 1'b0;

      ones = $countones(data) + int'(p);
      exp_data = data;
      exp_ok_e = (ones % 2 == 0);
      exp_ok_o = (ones % 2 == 1);
      if (!exp_ok_e && exp_err_e < 255) exp_err_e++;
      if (!exp_ok_o && exp_err_o < 3) exp_err_o++;
      latency = last_done_cyc - start_cyc;

      total++;
      if ({e_done, e_busy, e_data, e_ok} !== {1'b1, 1'b0, exp_data, exp_ok_e}) begin
         bad++; $display("FAIL %s even_done_cycle: done,busy,data,ok got %b,%b,%h,%b want 1,0,%h,%b",
                         name, e_done, e_busy, e_data, e_ok, exp_data, exp_ok_e);
      end
      total++;
      if ({o_done, o_busy, o_data, o_ok} !== {1'b1, 1'b0, exp_data, exp_ok_o}) begin
         bad++; $display("FAIL %s odd_done_cycle: done,busy,data,ok got %b,%b,%h,%b want 1,0,%h,%b",
                         name, o_done, o_busy, o_data, o_ok, exp_data, exp_ok_o);
      end
`ifdef PARITY_ERR_CNT_EN
      total++;
      if ({e_err, o_err} !== {8'(exp_err_e), 2'(exp_err_o)}) begin
         bad++; $display("FAIL %s err_count: got %0d/%0d want %0d/%0d", name, e_err, o_err, exp_err_e, exp_err_o);
      end
`endif
      start = glitch_done;
      tick();
      start = 1'b0;
      total++;
      if ({e_done, e_busy, o_done, o_busy} !== 4'b0000) begin
         bad++; $display("FAIL %s after_done: done,busy got %b want 0000", name, {e_done, e_busy, o_done, o_busy});
      end
      tick();
      total++;
      if ((done_e_cnt - e0 != 1) || (done_o_cnt - o0 != 1) || ({e_busy, o_busy} !== 2'b00)) begin
         bad++; $display("FAIL %s single_pulse_idle: pulses %0d/%0d busy %b want 1/1 00",
                         name, done_e_cnt - e0, done_o_cnt - o0, {e_busy, o_busy});
      end
   endtask

   task automatic test_reset();
      apply_reset();
      total++;
      if ({e_busy, e_data, e_ok, e_done, o_busy, o_data, o_ok, o_done} !== '0) begin
         bad++; $display("FAIL reset_values: even %b,%h,%b,%b odd %b,%h,%b,%b want all 0",
                         e_busy, e_data, e_ok, e_done, o_busy, o_data, o_ok, o_done);
      end
`ifdef PARITY_ERR_CNT_EN
      total++;
      if ({e_err, o_err} !== '0) begin
         bad++; $display("FAIL reset_err_count: got %0d/%0d want 0/0", e_err, o_err);
      end
`endif
      din_valid = 1'b1; din = 1'b1;
      tick(); tick();
      din_valid = 1'b0;
      total++;
      if ({e_busy, o_busy} !== 2'b00) begin
         bad++; $display("FAIL idle_ignores_din: busy got %b want 00", {e_busy, o_busy});
      end
   endtask

   task automatic test_basic();
      int lat;
      run_frame("a5_good", 8'hA5, 1'b0, 0, 0, 0, 1'b0, 1'b0, lat);
      total++;
      if (lat != 10 || e_ok !== 1'b1 || e_data !== 8'hA5) begin
         bad++; $display("FAIL a5_good_latency: latency %0d ok %b data %h want 10 1 a5", lat, e_ok, e_data);
      end
      run_frame("a5_bad", 8'hA5, 1'b1, 0, 0, 0, 1'b0, 1'b0, lat);
      total++;
      if (e_ok !== 1'b0) begin
         bad++; $display("FAIL a5_bad_verdict: got %b want 0", e_ok);
      end
   endtask

   task automatic test_stall();
      int lat;
      run_frame("3c_stall", 8'h3C, 1'b0, 0, 2, 3, 1'b0, 1'b0, lat);
      total++;
      if (lat != 15 || e_ok !== 1'b1 || e_data !== 8'h3C) begin
         bad++; $display("FAIL 3c_stall_latency: latency %0d ok %b data %h want 15 1 3c", lat, e_ok, e_data);
      end
   endtask

   task automatic test_reset_abort();
      int e0, o0, lat;
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         din_valid = 1'b1; din = 1'($urandom); tick();
      end
      din_valid = 1'b0;
      e0 = done_e_cnt; o0 = done_o_cnt;
      rst = 1'b1; tick(); rst = 1'b0;
      exp_data = '0; exp_ok_e = 1'b0; exp_ok_o = 1'b0; exp_err_e = 0; exp_err_o = 0;
      total++;
      if ({e_busy, e_data, e_ok, e_done, o_busy, o_data, o_ok, o_done} !== '0) begin
         bad++; $display("FAIL abort_cleared: even %b,%h,%b,%b odd %b,%h,%b,%b want all 0",
                         e_busy, e_data, e_ok, e_done, o_busy, o_data, o_ok, o_done);
      end
      din_valid = 1'b1;
      repeat (12) begin
         din = 1'($urandom); tick();
      end
      din_valid = 1'b0;
      total++;
      if ((done_e_cnt != e0) || (done_o_cnt != o0) || ({e_busy, o_busy} !== 2'b00)) begin
         bad++; $display("FAIL abort_no_done: pulses %0d/%0d busy %b want 0/0 00",
                         done_e_cnt - e0, done_o_cnt - o0, {e_busy, o_busy});
      end
      run_frame("ff_after_abort", 8'hFF, 1'b0, 0, 0, 0, 1'b0, 1'b0, lat);
      total++;
      if ({e_data, e_ok, o_ok} !== {8'hFF, 1'b1, 1'b0}) begin
         bad++; $display("FAIL ff_held: data %h ok %b/%b want ff 1/0", e_data, e_ok, o_ok);
      end
   endtask

   task automatic test_start_ignored();
      int lat;
      run_frame("start_glitch", 8'h96, 1'b0, 0, 0, 0, 1'b1, 1'b1, lat);
      run_frame("start_glitch_stall", 8'h4E, 1'b1, 1, 0, 1, 1'b1, 1'b1, lat);
   endtask

   task automatic test_random();
      int lat;
      for (int k = 0; k < 16; k++) begin
         run_frame("random", 8'($urandom), 1'($urandom), 2, 0, int'($urandom_range(2, 0)),
                   1'($urandom), 1'($urandom), lat);
      end
   endtask

   task automatic test_saturation();
      int lat;
      logic [1:0] want_seq [4];
      want_seq = '{2'd1, 2'd2, 2'd3, 2'd3};
      apply_reset();
      for (int k = 0; k < 4; k++) begin
         run_frame("sat_bad", 8'h01, 1'b1, 0, 0, 0, 1'b0, 1'b0, lat);
         total++;
         if (o_ok !== 1'b0) begin
            bad++; $display("FAIL sat_bad_verdict: odd ok got %b want 0", o_ok);
         end
`ifdef PARITY_ERR_CNT_EN
         total++;
         if (o_err !== want_seq[k]) begin
            bad++; $display("FAIL sat_sequence: frame %0d err_count got %0d want %0d", k, o_err, want_seq[k]);
         end
`endif
      end
      run_frame("sat_good", 8'h01, 1'b0, 0, 0, 0, 1'b0, 1'b0, lat);
      total++;
      if (o_ok !== 1'b1) begin
         bad++; $display("FAIL sat_good_verdict: odd ok got %b want 1", o_ok);
      end
`ifdef PARITY_ERR_CNT_EN
      total++;
      if (o_err !== 2'd3) begin
         bad++; $display("FAIL sat_hold: err_count got %0d want 3", o_err);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_reset_abort();
      test_start_ignored();
      test_random();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
